// File: rtl/dw03_bictr_encode_pkg.sv
// Shared types and helpers for the bidirectional counter one-hot decoder.
// Holds the tracker state encoding and the one-hot width rule.
package dw03_bictr_encode_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } state_e;

    function automatic int onehot_w(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/dw03_bictr_encode_if.sv
// Sample/result bundle between the upstream counter and the encoder.
// The master drives samples; the slave returns the registered result.
interface dw03_bictr_encode_if #(
    parameter int WIDTH = 8
);
    import dw03_bictr_encode_pkg::*;

    localparam int N = onehot_w(WIDTH);

    logic             in_valid;
    logic [N-1:0]     count_dec;
    logic             load_seen;
    logic             clr_err;
    logic             out_valid;
    logic [WIDTH-1:0] count_bin;
    logic             dir;
    logic             wrap;
    logic             err_onehot;
    logic             err_step;
    logic             err_sticky;

    modport master (
        output in_valid,
        output count_dec,
        output load_seen,
        output clr_err,
        input  out_valid,
        input  count_bin,
        input  dir,
        input  wrap,
        input  err_onehot,
        input  err_step,
        input  err_sticky
    );

    modport slave (
        input  in_valid,
        input  count_dec,
        input  load_seen,
        input  clr_err,
        output out_valid,
        output count_bin,
        output dir,
        output wrap,
        output err_onehot,
        output err_step,
        output err_sticky
    );

endinterface

// File: rtl/dw03_onehot_enc.sv
// Combinational one-hot to binary encoder with popcount legality check.
// The binary output is a plain OR-tree, so illegal inputs merge bits.
module dw03_onehot_enc
    import dw03_bictr_encode_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [onehot_w(WIDTH)-1:0] onehot_i,
    output logic [WIDTH-1:0]           bin_o,
    output logic                       legal_o
);

    localparam int N = onehot_w(WIDTH);

    logic [WIDTH:0] ones;

    always_comb begin
        bin_o = '0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int i = 0; i < N; i++) begin
                if (i[k]) begin
                    bin_o[k] = bin_o[k] | onehot_i[i];
                end
            end
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + (WIDTH+1)'(onehot_i[i]);
        end
    end

    assign legal_o = (ones == (WIDTH+1)'(1));

endmodule

// File: rtl/dw03_bictr_encode.sv
// Tracks an up/down counter from its one-hot decode and flags bad samples.
// One registered result per accepted sample; clr_err re-arms the tracker.
module dw03_bictr_encode
    import dw03_bictr_encode_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    dw03_bictr_encode_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             ov_q, ov_d;
    logic             wrap_q, wrap_d;
    logic             eoh_q, eoh_d;
    logic             estep_q, estep_d;

    logic [WIDTH-1:0] bin;
    logic             legal;
    logic [WIDTH-1:0] inc_v;
    logic [WIDTH-1:0] dec_v;
    logic             is_load;
    logic             is_hold;
    logic             is_up;
    logic             is_dn;

    dw03_onehot_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .onehot_i (bus.count_dec),
        .bin_o    (bin),
        .legal_o  (legal)
    );

    assign inc_v = cnt_q + ONE;
    assign dec_v = cnt_q - ONE;

    // Mutually exclusive step classes; up wins when +1 and -1 coincide.
    assign is_load = bus.load_seen;
    assign is_hold = !is_load && (bin == cnt_q);
    assign is_up   = !is_load && !is_hold && (bin == inc_v);
    assign is_dn   = !is_load && !is_hold && !is_up && (bin == dec_v);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        ov_d    = 1'b0;
        wrap_d  = 1'b0;
        eoh_d   = 1'b0;
        estep_d = 1'b0;
        if (bus.clr_err) begin
            state_d = UNSYNC;
        end else if (bus.in_valid) begin
            ov_d = 1'b1;
            if (!legal) begin
                eoh_d = 1'b1;
                if (state_q == TRACK) begin
                    state_d = FAULT;
                end
            end else begin
                unique case (state_q)
                    UNSYNC: begin
                        cnt_d   = bin;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        unique case (1'b1)
                            is_load: cnt_d = bin;
                            is_hold: cnt_d = cnt_q;
                            is_up: begin
                                cnt_d  = bin;
                                dir_d  = 1'b1;
                                wrap_d = (cnt_q == MAXV);
                            end
                            is_dn: begin
                                cnt_d  = bin;
                                dir_d  = 1'b0;
                                wrap_d = (cnt_q == '0);
                            end
                            default: begin
                                estep_d = 1'b1;
                                state_d = FAULT;
                            end
                        endcase
                    end
                    FAULT: state_d = FAULT;
                    default: state_d = UNSYNC;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNSYNC;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            ov_q    <= 1'b0;
            wrap_q  <= 1'b0;
            eoh_q   <= 1'b0;
            estep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ov_q    <= ov_d;
            wrap_q  <= wrap_d;
            eoh_q   <= eoh_d;
            estep_q <= estep_d;
        end
    end

    assign bus.out_valid  = ov_q;
    assign bus.count_bin  = cnt_q;
    assign bus.dir        = dir_q;
    assign bus.wrap       = wrap_q;
    assign bus.err_onehot = eoh_q;
    assign bus.err_step   = estep_q;
    assign bus.err_sticky = (state_q == FAULT);

endmodule

// File: tb/tb_dw03_bictr_encode.sv
// Bench for dw03_bictr_encode at WIDTH=3: directed scenarios plus random
// traffic, all checked against a rule-level reference model.
module tb_dw03_bictr_encode;

    localparam int W = 3;
    localparam int M = 8;

    logic clk;
    logic rst;

    dw03_bictr_encode_if #(.WIDTH(W)) bus ();

    dw03_bictr_encode #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: 0 = unsync, 1 = track, 2 = fault
    int m_state = 0;
    int m_cnt   = 0;
    bit m_dir   = 1'b1;
    bit e_ov, e_wrap, e_eo, e_es;

    function automatic logic [8:0] obs();
        return {bus.out_valid, bus.count_bin, bus.dir, bus.wrap,
                bus.err_onehot, bus.err_step, bus.err_sticky};
    endfunction

    function automatic logic [8:0] expv();
        return {e_ov, 3'(m_cnt), m_dir, e_wrap, e_eo, e_es, (m_state == 2)};
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input bit l,
                         input bit c, input bit r);
        int pc;
        int val;
        bus.in_valid  = v;
        bus.count_dec = d;
        bus.load_seen = l;
        bus.clr_err   = c;
        rst           = r;
        @(posedge clk);
        #1;
        e_ov = 0; e_wrap = 0; e_eo = 0; e_es = 0;
        if (r) begin
            m_state = 0; m_cnt = 0; m_dir = 1'b1;
        end else if (c) begin
            m_state = 0;
        end else if (v) begin
            e_ov = 1;
            pc = $countones(d);
            if (pc != 1) begin
                e_eo = 1;
                if (m_state == 1) m_state = 2;
            end else begin
                val = 0;
                for (int i = 0; i < M; i++) if (d[i]) val = i;
                if (m_state == 0) begin
                    m_cnt = val; m_state = 1;
                end else if (m_state == 1) begin
                    if (l) m_cnt = val;
                    else if (val == m_cnt) m_cnt = val;
                    else if (val == (m_cnt + 1) % M) begin
                        e_wrap = (val == 0); m_dir = 1'b1; m_cnt = val;
                    end else if (val == (m_cnt + M - 1) % M) begin
                        e_wrap = (val == M - 1); m_dir = 1'b0; m_cnt = val;
                    end else begin
                        e_es = 1; m_state = 2;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(1, 8'h10, 0, 1, 1);
        drive(0, 8'h00, 0, 0, 1);
        total++;
        if (obs() !== 9'b0_000_1_0_0_0_0) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", obs(), 9'b0_000_1_0_0_0_0);
        end
        drive(0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_count_up();
        logic [7:0] pat [3] = '{8'h01, 8'h02, 8'h04};
        for (int i = 0; i < 3; i++) begin
            drive(1, pat[i], 0, 0, 0);
            total++;
            if (obs() !== expv() || bus.count_bin !== 3'(i) || !bus.out_valid) begin
                bad++;
                $display("FAIL count_up[%0d] got=%b exp=%b", i, obs(), expv());
            end
        end
        total++;
        if (bus.dir !== 1'b1) begin
            bad++;
            $display("FAIL count_up_dir got=%b exp=1", bus.dir);
        end
        drive(0, 8'h00, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        for (int i = 3; i < 8; i++) begin
            d = 8'h01 << i;
            drive(1, d, 0, 0, 0);
        end
        drive(1, 8'h01, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.count_bin !== 3'd0 || bus.wrap !== 1'b1
            || bus.dir !== 1'b1) begin
            bad++;
            $display("FAIL wrap_up got=%b exp=%b", obs(), expv());
        end
        drive(1, 8'h80, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.count_bin !== 3'd7 || bus.wrap !== 1'b1
            || bus.dir !== 1'b0) begin
            bad++;
            $display("FAIL wrap_dn got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_onehot_err();
        drive(1, 8'h00, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.err_onehot !== 1'b1 || bus.err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL onehot_zero got=%b exp=%b", obs(), expv());
        end
        drive(1, 8'h05, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.err_onehot !== 1'b1 || bus.count_bin !== 3'd7) begin
            bad++;
            $display("FAIL onehot_multi got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_step_err();
        drive(0, 8'h00, 0, 1, 0);
        drive(1, 8'h04, 0, 0, 0);
        drive(1, 8'h40, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.err_step !== 1'b1 || bus.count_bin !== 3'd2
            || bus.err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL step_err got=%b exp=%b", obs(), expv());
        end
        drive(0, 8'h00, 0, 1, 0);
        drive(1, 8'h04, 0, 0, 0);
        drive(1, 8'h40, 1, 0, 0);
        total++;
        if (obs() !== expv() || bus.count_bin !== 3'd6 || bus.err_step !== 1'b0
            || bus.err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL step_load got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_clear();
        drive(1, 8'h01, 0, 0, 0);
        drive(1, 8'h02, 0, 1, 0);
        total++;
        if (obs() !== expv() || bus.out_valid !== 1'b0 || bus.err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL clear got=%b exp=%b", obs(), expv());
        end
        drive(1, 8'h08, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.count_bin !== 3'd3 || bus.err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL resync got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_reset_priority();
        drive(1, 8'h10, 0, 0, 0);
        drive(1, 8'h10, 0, 1, 1);
        total++;
        if (obs() !== 9'b0_000_1_0_0_0_0) begin
            bad++;
            $display("FAIL rst_prio got=%b exp=%b", obs(), 9'b0_000_1_0_0_0_0);
        end
        drive(1, 8'h20, 0, 0, 0);
        total++;
        if (obs() !== expv() || bus.count_bin !== 3'd5) begin
            bad++;
            $display("FAIL rst_unsync got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] one;
        int sel;
        int v;
        bit vl, ld, cl, rs;
        one = 8'h01;
        for (int n = 0; n < 600; n++) begin
            vl = ($urandom_range(0, 9) < 8);
            ld = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 59) == 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: v = m_cnt;
                2, 3: v = (m_cnt + 1) % M;
                4, 5: v = (m_cnt + M - 1) % M;
                6:    v = $urandom_range(0, M - 1);
                default: v = -1;
            endcase
            if (v < 0) d = 8'($urandom);
            else d = one << v;
            drive(vl, d, ld, cl, rs);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random[%0d] got=%b exp=%b", n, obs(), expv());
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.count_dec = '0;
        bus.load_seen = 1'b0;
        bus.clr_err   = 1'b0;
        test_reset();
        test_count_up();
        test_wrap();
        test_onehot_err();
        test_step_err();
        test_clear();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dw03_bictr_encode.md
DW03_BICTR_ENCODE -- requirements
Module: dw03_bictr_encode

Interface
REQ-001 Parameter: WIDTH, default 8, binary count width; the one-hot input is 2**WIDTH bits; legal range 1..16.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  count_dec is sampled this cycle.
REQ-005 count_dec  input  2**WIDTH  decoded (one-hot) counter value from the upstream up/down counter.
REQ-006 load_seen  input  1  upstream preset occurred; qualifies the same-cycle sample as an arbitrary jump.
REQ-007 clr_err  input  1  clears FAULT and the sticky error, returning to UNSYNC.
REQ-008 out_valid  output  1  registered result valid, one-cycle pulse.
REQ-009 count_bin  output  WIDTH  binary value of the last legal one-hot sample.
REQ-010 dir  output  1  last observed direction: 1 = up, 0 = down.
REQ-011 wrap  output  1  one-cycle pulse on max->0 (up) or 0->max (down).
REQ-012 err_onehot  output  1  one-cycle pulse: sample had zero bits or more than one bit set.
REQ-013 err_step  output  1  one-cycle pulse: legal one-hot sample violated step rules.
REQ-014 err_sticky  output  1  level: high while in FAULT.

Function
REQ-015 Latency SHALL be exactly 1 cycle: in_valid at edge N produces out_valid, the flags and the updated count_bin/dir visible after edge N+1. No back-pressure exists.
REQ-016 One-hot check SHALL use the popcount of count_dec: 1 is legal; 0 or >1 raises err_onehot with out_valid and leaves count_bin and dir unchanged.
REQ-017 The encoding SHALL be a pure OR-tree: bit k of count_bin = OR of count_dec[i] over all i with bit k of i set; there is no priority.
REQ-018 State machine states: UNSYNC, TRACK, FAULT.
REQ-019 UNSYNC, legal sample: load count_bin, go to TRACK, no step check, dir unchanged, wrap=0.
REQ-020 TRACK, legal sample, with prev = count_bin:
- new = prev+1 mod 2**WIDTH: dir=1.
- new = prev-1 mod 2**WIDTH: dir=0.
- new = prev (counter disabled): dir held.
- any other value: err_step, go to FAULT, count_bin unchanged.
REQ-021 For WIDTH=1, +1 and -1 coincide; the change SHALL be treated as up (dir=1).
REQ-022 In TRACK, load_seen=1 with a legal sample SHALL accept any value without a step check; dir held, wrap=0.
REQ-023 wrap SHALL pulse only on an accepted step in TRACK: prev=2**WIDTH-1 -> 0 with dir=1, or prev=0 -> 2**WIDTH-1 with dir=0.
REQ-024 An illegal one-hot sample in TRACK SHALL also go to FAULT; in UNSYNC it SHALL stay in UNSYNC.
REQ-025 In FAULT, samples SHALL still produce out_valid and err_onehot, but count_bin and dir are frozen and err_step is not raised.
REQ-026 clr_err SHALL take priority over in_valid: the state goes to UNSYNC, the same-cycle sample is discarded, and out_valid=0.
REQ-027 wrap, err_onehot, err_step and out_valid SHALL be 0 whenever in_valid was 0 in the previous cycle.

Reset
REQ-028 rst SHALL have priority over every other input, including clr_err.
REQ-029 Reset values: state=UNSYNC, count_bin=0, dir=1, out_valid=0, wrap=0, err_onehot=0, err_step=0, err_sticky=0.
REQ-030 Asserting rst mid-stream SHALL discard the sample in flight; the first legal sample after reset is treated as in UNSYNC.

Structure
REQ-031 A shared package SHALL hold the state enum (UNSYNC/TRACK/FAULT) and a function computing one-hot width from WIDTH.
REQ-032 The OR-tree encoder plus popcount SHALL form one combinational sub-module, dw03_onehot_enc, with outputs bin and legal.

Verification (WIDTH=3)
REQ-033 Reset, then samples 0x01,0x02,0x04 -> count_bin 0,1,2; dir=1; no errors; out_valid one cycle after each sample.
REQ-034 From count 7, sample 0x01 -> count_bin=0, wrap=1, dir=1; from 0, sample 0x80 -> count_bin=7, wrap=1, dir=0.
REQ-035 Sample 0x00, then 0x05 in TRACK -> err_onehot pulses twice, state FAULT, err_sticky=1, count_bin held.
REQ-036 Count 2 then sample 0x40 -> err_step=1, FAULT; the same jump with load_seen=1 -> count_bin=6, no error.
REQ-037 In FAULT: clr_err together with a sample -> no out_valid; next 0x08 -> count_bin=3 (UNSYNC re-sync), err_sticky=0.
REQ-038 rst asserted together with clr_err and in_valid -> all outputs at reset values on the next cycle.
